alu_result_queue: RTL and testbench

Downstream capture stage for the 4-bit ALU. Each cycle it can accept one ALU result together with its opcode and flags, through a valid/ready handshake. Results are held in a small in-order FIFO and presented to the consumer (display/trace logic) through a second valid/ready handshake. Optional sticky flag registers accumulate carry, zero and overflow across accepted add/sub operations.

---
 rtl/alu_result_queue_if.sv | 28 ++
 rtl/alu_result_queue.sv | 112 +++++++++++
 tb/tb_alu_result_queue.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_queue_if.sv
// Producer/consumer handshake bundle for alu_result_queue.
// The queue connects to the slave modport; the producer and consumer side uses master.
interface alu_result_queue_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [3:0] in_res;
   logic       in_carry;
   logic       in_zero;
   logic       in_ovf;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_op;
   logic [3:0] out_res;
   logic       out_carry;
   logic       out_zero;
   logic       out_ovf;

   modport slave (
      input  in_valid, in_op, in_res, in_carry, in_zero, in_ovf, out_ready,
      output in_ready, out_valid, out_op, out_res, out_carry, out_zero, out_ovf
   );

   modport master (
      output in_valid, in_op, in_res, in_carry, in_zero, in_ovf, out_ready,
      input  in_ready, out_valid, out_op, out_res, out_carry, out_zero, out_ovf
   );
endinterface

// File: rtl/alu_result_queue.sv
// In-order ALU result FIFO: 1-cycle push-to-valid, in_ready from registered count only.
// Optional sticky carry/zero/overflow accumulators are built when ALU_RESQ_STICKY_EN is defined.
module alu_result_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   alu_result_queue_if.slave q,
   output logic [CNT_W-1:0] count,
   input  logic             flag_clr,
   output logic             sticky_carry,
   output logic             sticky_zero,
   output logic             sticky_ovf
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [2:0] op;
      logic       carry;
      logic       zero;
      logic       ovf;
      logic [3:0] res;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] head_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop, arith;
   entry_t           in_entry, head;

   // Flags are only meaningful for add/sub; everything else is stored with flags cleared.
   assign arith = (q.in_op[2:1] == 2'b00);

   always_comb begin
      in_entry       = '0;
      in_entry.op    = q.in_op;
      in_entry.carry = q.in_carry & arith;
      in_entry.zero  = q.in_zero  & arith;
      in_entry.ovf   = q.in_ovf   & arith;
      in_entry.res   = q.in_res;
   end

   assign q.in_ready  = (count_q != CNT_W'(DEPTH));
   assign q.out_valid = (count_q != '0);
   assign push        = q.in_valid  && q.in_ready;
   assign pop         = q.out_valid && q.out_ready;

   // When empty, rd_ptr-1 is the slot written last, so the outputs keep showing it.
   assign head_ptr    = q.out_valid ? rd_ptr_q : rd_ptr_q - PTR_W'(1);
   assign head        = mem_q[head_ptr];
   assign q.out_op    = head.op;
   assign q.out_res   = head.res;
   assign q.out_carry = head.carry;
   assign q.out_zero  = head.zero;
   assign q.out_ovf   = head.ovf;
   assign count       = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q] <= in_entry;
      end
   end

`ifdef ALU_RESQ_STICKY_EN
   logic [2:0] sticky_q, sticky_d;

   // A push in the same cycle as flag_clr still lands, since the OR follows the clear.
   always_comb begin
      sticky_d = (flag_clr ? 3'b000 : sticky_q) |
                 (push ? {in_entry.carry, in_entry.zero, in_entry.ovf} : 3'b000);
   end

   always_ff @(posedge clk) begin
      if (rst) sticky_q <= '0;
      else     sticky_q <= sticky_d;
   end

   assign sticky_carry = sticky_q[2];
   assign sticky_zero  = sticky_q[1];
   assign sticky_ovf   = sticky_q[0];
`else
   logic unused_flag_clr;
   assign unused_flag_clr = flag_clr;
   assign sticky_carry    = 1'b0;
   assign sticky_zero     = 1'b0;
   assign sticky_ovf      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (DEPTH=4), sticky expectations follow ALU_RESQ_STICKY_EN.
module tb_alu_result_queue;
`ifdef ALU_RESQ_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] count;
   logic       flag_clr;
   logic       sticky_carry, sticky_zero, sticky_ovf;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   alu_result_queue_if bus ();

   alu_result_queue #(.DEPTH(4), .CNT_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .q            (bus.slave),
      .count        (count),
      .flag_clr     (flag_clr),
      .sticky_carry (sticky_carry),
      .sticky_zero  (sticky_zero),
      .sticky_ovf   (sticky_ovf)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [2:0] op, input logic [3:0] res,
                           input logic c, input logic z, input logic o);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_res   = res;
      bus.in_carry = c;
      bus.in_zero  = z;
      bus.in_ovf   = o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total_cnt++;
      if ({count, bus.in_ready, bus.out_valid} !== {3'd0, 1'b1, 1'b0})
         $display("FAIL reset_ctrl: count/in_ready/out_valid got %b want 00010", {count, bus.in_ready, bus.out_valid});
      else pass_cnt++;
      total_cnt++;
      if ({bus.out_op, bus.out_res, bus.out_carry, bus.out_zero, bus.out_ovf} !== 10'd0)
         $display("FAIL reset_data: head got %b want 0", {bus.out_op, bus.out_res, bus.out_carry, bus.out_zero, bus.out_ovf});
      else pass_cnt++;
      total_cnt++;
      if ({sticky_carry, sticky_zero, sticky_ovf} !== 3'b000)
         $display("FAIL reset_sticky: got %b want 000", {sticky_carry, sticky_zero, sticky_ovf});
      else pass_cnt++;
   endtask

   task automatic test_single_push();
      drive_in(1'b1, 3'b000, 4'b0111, 1'b0, 1'b0, 1'b0);
      step();
      drive_in(1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({bus.out_valid, count, bus.out_op, bus.out_res} !== {1'b1, 3'd1, 3'b000, 4'b0111})
         $display("FAIL single_push: valid/count/op/res got %b want 1001000 0111", {bus.out_valid, count, bus.out_op, bus.out_res});
      else pass_cnt++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total_cnt++;
      if ({count, bus.out_valid} !== {3'd0, 1'b0})
         $display("FAIL single_pop: count/valid got %b want 0000", {count, bus.out_valid});
      else pass_cnt++;
      total_cnt++;
      if (bus.out_res !== 4'b0111)
         $display("FAIL empty_hold: out_res got %h want 7", bus.out_res);
      else pass_cnt++;
   endtask

   task automatic test_fill_stall();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive_in(1'b1, 3'b000, 4'(k), 1'b0, 1'b0, 1'b0);
         step();
      end
      total_cnt++;
      if ({bus.in_ready, count} !== {1'b0, 3'd4})
         $display("FAIL fill_full: in_ready/count got %b want 0100", {bus.in_ready, count});
      else pass_cnt++;
      drive_in(1'b1, 3'b000, 4'd5, 1'b0, 1'b0, 1'b0);
      step();
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({count, bus.out_res} !== {3'd4, 4'd1})
         $display("FAIL stall_hold: count/head got %b want 100 0001", {count, bus.out_res});
      else pass_cnt++;
      for (int k = 1; k <= 4; k++) begin
         total_cnt++;
         if (bus.out_res !== 4'(k))
            $display("FAIL fill_order: out_res got %h want %h", bus.out_res, 4'(k));
         else pass_cnt++;
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
      end
      total_cnt++;
      if (count !== 3'd0)
         $display("FAIL fill_drain: count got %0d want 0", count);
      else pass_cnt++;
   endtask

   task automatic test_push_pop_full();
      logic [3:0] exp_res [4];
      exp_res = '{4'h9, 4'hA, 4'hB, 4'hC};
      for (int k = 8; k <= 11; k++) begin
         drive_in(1'b1, 3'b001, 4'(k), 1'b0, 1'b0, 1'b0);
         step();
      end
      drive_in(1'b1, 3'b001, 4'hC, 1'b0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total_cnt++;
      if ({count, bus.in_ready} !== {3'd3, 1'b1})
         $display("FAIL full_pop_only: count/in_ready got %b want 0111", {count, bus.in_ready});
      else pass_cnt++;
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (count !== 3'd4)
         $display("FAIL full_repush: count got %0d want 4", count);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (bus.out_res !== exp_res[k])
            $display("FAIL full_order: out_res got %h want %h", bus.out_res, exp_res[k]);
         else pass_cnt++;
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_wrap();
      int sent = 0;
      int nxt  = 0;
      int over = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 30 && nxt < 10; i++) begin
         drive_in(sent < 10, 3'b000, 4'(sent), 1'b0, 1'b0, 1'b0);
         if (bus.out_valid) begin
            total_cnt++;
            if (bus.out_res !== 4'(nxt))
               $display("FAIL wrap_order: out_res got %h want %h", bus.out_res, 4'(nxt));
            else pass_cnt++;
            nxt++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         if (count > 3'd2) over++;
      end
      bus.out_ready = 1'b0;
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (nxt != 10 || over != 0)
         $display("FAIL wrap_done: popped %0d (want 10), cycles with count>2 %0d (want 0)", nxt, over);
      else pass_cnt++;
   endtask

   task automatic test_flag_mask();
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive_in(1'b1, 3'b011, 4'h5, 1'b1, 1'b1, 1'b1);
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({bus.out_carry, bus.out_zero, bus.out_ovf, sticky_carry, sticky_zero, sticky_ovf} !== 6'b0)
         $display("FAIL mask_logic: stored+sticky flags got %b want 000000",
                  {bus.out_carry, bus.out_zero, bus.out_ovf, sticky_carry, sticky_zero, sticky_ovf});
      else pass_cnt++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      drive_in(1'b1, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b0);
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({bus.out_carry, bus.out_zero, bus.out_ovf} !== 3'b110)
         $display("FAIL mask_sub: stored flags got %b want 110", {bus.out_carry, bus.out_zero, bus.out_ovf});
      else pass_cnt++;
      total_cnt++;
      if ({sticky_carry, sticky_zero, sticky_ovf} !== {STK, STK, 1'b0})
         $display("FAIL sticky_sub: got %b want %b", {sticky_carry, sticky_zero, sticky_ovf}, {STK, STK, 1'b0});
      else pass_cnt++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_clr_and_reset();
      flag_clr = 1'b1;
      drive_in(1'b1, 3'b000, 4'h3, 1'b0, 1'b0, 1'b1);
      step();
      flag_clr = 1'b0;
      total_cnt++;
      if ({sticky_carry, sticky_zero, sticky_ovf} !== {1'b0, 1'b0, STK})
         $display("FAIL clr_vs_push: got %b want %b", {sticky_carry, sticky_zero, sticky_ovf}, {1'b0, 1'b0, STK});
      else pass_cnt++;
      drive_in(1'b1, 3'b000, 4'h4, 1'b1, 1'b0, 1'b0);
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({sticky_carry, sticky_zero, sticky_ovf} !== {STK, 1'b0, STK})
         $display("FAIL sticky_accum: got %b want %b", {sticky_carry, sticky_zero, sticky_ovf}, {STK, 1'b0, STK});
      else pass_cnt++;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      total_cnt++;
      if ({sticky_carry, sticky_zero, sticky_ovf} !== 3'b000)
         $display("FAIL clr_only: got %b want 000", {sticky_carry, sticky_zero, sticky_ovf});
      else pass_cnt++;
      drive_in(1'b1, 3'b010, 4'h6, 1'b0, 1'b0, 1'b0);
      step();
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (count !== 3'd3)
         $display("FAIL pre_reset: count got %0d want 3", count);
      else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++;
      if ({count, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1})
         $display("FAIL mid_reset: count/valid/ready got %b want 00001", {count, bus.out_valid, bus.in_ready});
      else pass_cnt++;
   endtask

   initial begin
      rst           = 1'b1;
      flag_clr      = 1'b0;
      bus.out_ready = 1'b0;
      drive_in(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_single_push();
      test_fill_stall();
      test_push_pop_full();
      test_wrap();
      test_flag_mask();
      test_clr_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
